c3po_reg_master: RTL

- Initiator for the C-3PO register bus (addr/rd_wr/req/write_val/read_val/ack).
- Accepts one register command at a time from a host/sequencer on a valid/ready interface and drives one bus transaction.
- Waits for ack, then returns read data or error status on a valid/ready response interface.
- Sits between the config host and the c3po register bank.

---
 rtl/c3po_regm_pkg.sv | 16 +
 rtl/c3po_reg_master_if.sv | 35 +++
 rtl/c3po_regm_timer.sv | 32 +++
 rtl/c3po_reg_master.sv | 132 +++++++++++++
 4 files changed

// File: rtl/c3po_regm_pkg.sv
// Shared types and constants for the C-3PO register bus initiator.
package c3po_regm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } c3po_regm_state_e;

   localparam logic RD_WR_READ  = 1'b0;
   localparam logic RD_WR_WRITE = 1'b1;

   localparam int          TIMEOUT_DEF  = 16;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_C3B0;

endpackage

// File: rtl/c3po_reg_master_if.sv
// Host command/response channels plus the C-3PO register bus, as seen by the initiator.
interface c3po_reg_master_if #(
   parameter int ADDR_SIZE_P = 6,
   parameter int DATA_W_P    = 32
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_rd_wr;
   logic [ADDR_SIZE_P-1:0] cmd_addr;
   logic [DATA_W_P-1:0]    cmd_wdata;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [DATA_W_P-1:0]    rsp_data;
   logic                   rsp_err;
   logic                   rsp_wr;

   logic [ADDR_SIZE_P-1:0] addr;
   logic                   rd_wr;
   logic                   req;
   logic [DATA_W_P-1:0]    write_val;
   logic [DATA_W_P-1:0]    read_val;
   logic                   ack;

   // master: the initiator itself; slave: host plus register bank side
   modport master (
      input  cmd_valid, cmd_rd_wr, cmd_addr, cmd_wdata, rsp_ready, read_val, ack,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_wr, addr, rd_wr, req, write_val
   );

   modport slave (
      output cmd_valid, cmd_rd_wr, cmd_addr, cmd_wdata, rsp_ready, read_val, ack,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_wr, addr, rd_wr, req, write_val
   );
endinterface

// File: rtl/c3po_regm_timer.sv
// Saturating bus-wait counter: clear loads zero, enable counts up, expired flags TIMEOUT_P-1.
module c3po_regm_timer
   import c3po_regm_pkg::*;
#(
   parameter int TIMEOUT_P = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int            TW   = $clog2(TIMEOUT_P);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_P - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != LAST))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == LAST);
endmodule

// File: rtl/c3po_reg_master.sv
// C-3PO register bus initiator: one command in, one bus transaction, one response out.
// Bus timeout is built only when C3PO_REG_MASTER_TIMEOUT_EN is defined.
module c3po_reg_master
   import c3po_regm_pkg::*;
#(
   parameter int                 ADDR_SIZE_P = 6,
   parameter int                 DATA_W_P    = 32,
   parameter int                 TIMEOUT_P   = TIMEOUT_DEF,
   parameter logic [DATA_W_P-1:0] ERR_DATA_P = DATA_W_P'(ERR_DATA_DEF)
) (
   input  logic                clk,
   input  logic                reset,
   c3po_reg_master_if.master   bus
);
   c3po_regm_state_e       state_q, state_d;
   logic [ADDR_SIZE_P-1:0] addr_q, addr_d;
   logic                   rd_wr_q, rd_wr_d;
   logic [DATA_W_P-1:0]    wdata_q, wdata_d;
   logic                   req_q, req_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [DATA_W_P-1:0]    rsp_data_q, rsp_data_d;
   logic                   rsp_err_q, rsp_err_d;
   logic                   rsp_wr_q, rsp_wr_d;
   logic                   tmr_clr, tmr_en, tmr_expired;
   logic                   cmd_ready;

   assign cmd_ready = (state_q == IDLE) && !reset;

`ifdef C3PO_REG_MASTER_TIMEOUT_EN
   c3po_regm_timer #(.TIMEOUT_P(TIMEOUT_P)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );
`else
   // Without the timer BUS waits for ack forever; the timeout parameters only keep the interface uniform.
   assign tmr_expired = 1'b0;
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = tmr_clr ^ tmr_en ^ (^ERR_DATA_P) ^ (TIMEOUT_P == 0);
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rd_wr_d     = rd_wr_q;
      wdata_d     = wdata_q;
      req_d       = req_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      rsp_wr_d    = rsp_wr_q;
      tmr_clr     = 1'b0;
      tmr_en      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready) begin
               addr_d  = bus.cmd_addr;
               rd_wr_d = bus.cmd_rd_wr;
               wdata_d = bus.cmd_wdata;
               req_d   = 1'b1;
               tmr_clr = 1'b1;
               state_d = BUS;
            end
         end
         BUS: begin
            // ack takes priority over a timeout landing in the same cycle
            if (bus.ack) begin
               req_d       = 1'b0;
               rsp_data_d  = (rd_wr_q == RD_WR_WRITE) ? '0 : bus.read_val;
               rsp_err_d   = 1'b0;
               rsp_wr_d    = rd_wr_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (tmr_expired) begin
`ifdef C3PO_REG_MASTER_TIMEOUT_EN
               rsp_data_d  = ERR_DATA_P;
`endif
               req_d       = 1'b0;
               rsp_err_d   = 1'b1;
               rsp_wr_d    = rd_wr_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               tmr_en = 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rd_wr_q     <= 1'b0;
         wdata_q     <= '0;
         req_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rd_wr_q     <= rd_wr_d;
         wdata_q     <= wdata_d;
         req_q       <= req_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rsp_wr_q    <= rsp_wr_d;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.addr      = addr_q;
   assign bus.rd_wr     = rd_wr_q;
   assign bus.write_val = wdata_q;
   assign bus.req       = req_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_wr    = rsp_wr_q;
endmodule
